// File: rtl/usb_transmitter.sv
// USB low-level packet transmitter: SYNC, NRZI-coded payload and EOP from a one-byte pending buffer.
// Define USB_TX_BIT_STUFF_EN to insert a stuff bit after six consecutive transmitted ones.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line at J, ready for the first byte of a packet
// SYNC    | shifting out the 8'h80 sync pattern
// DATA    | shifting out payload bits, LSB first
// STUFF   | one inserted bit time (line toggle), no payload consumed
// EOP_SE0 | both lines low for two bit times
// EOP_J   | line at J for one bit time before returning to IDLE

module usb_transmitter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       transmitting,
  output logic       tx_error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TC_LOAD = TW'(CLKS_PER_BIT - 1);

`ifdef USB_TX_BIT_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t        state;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [2:0]    ones_cnt;
  logic [7:0]    shift_data;
  logic          shift_last;
  logic [7:0]    pend_data;
  logic          pend_last;
  logic          pend_valid;

  logic       accept;
  logic       bit_end;
  logic       byte_end;
  logic       stuff_due;
  logic       have_next;
  logic       advancing;
  logic       load_next;
  logic [7:0] next_data;
  logic       next_last;
  logic [2:0] adv_idx;
  logic       adv_bit;

  // SYNC is carried in the shifter, so its last bit is an ordinary byte boundary
  assign tx_ready  = (state == IDLE) ||
                     ((state == SYNC || state == DATA) && byte_end && !shift_last && !pend_valid);
  assign accept    = tx_valid && tx_ready;
  assign bit_end   = (bit_timer == '0);
  assign byte_end  = (bit_idx == 3'd7);
  assign stuff_due = STUFF_EN && (ones_cnt == 3'd6);
  assign have_next = pend_valid || accept;
  assign next_data = pend_valid ? pend_data : tx_data;
  assign next_last = pend_valid ? pend_last : tx_last;
  assign advancing = bit_end &&
                     (state == SYNC || state == STUFF || (state == DATA && !stuff_due));
  assign load_next = advancing && byte_end && !shift_last && have_next;

  always_comb begin
    adv_idx = bit_idx + 3'd1;
    adv_bit = shift_data[adv_idx];
    if (byte_end) begin
      adv_idx = 3'd0;
      adv_bit = next_data[0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_last  <= 1'b0;
    end else if (load_next) begin
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_data  <= tx_data;
      pend_last  <= tx_last;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      bit_timer    <= '0;
      bit_idx      <= '0;
      ones_cnt     <= '0;
      shift_data   <= '0;
      shift_last   <= 1'b0;
      d_plus       <= 1'b1;
      d_minus      <= 1'b0;
      transmitting <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          d_plus       <= 1'b1;
          d_minus      <= 1'b0;
          transmitting <= 1'b0;
          if (accept) begin
            state        <= SYNC;
            transmitting <= 1'b1;
            shift_data   <= 8'h80;
            shift_last   <= 1'b0;
            bit_idx      <= 3'd0;
            ones_cnt     <= 3'd0;
            bit_timer    <= TC_LOAD;
            d_plus       <= 1'b0;
            d_minus      <= 1'b1;
          end
        end

        SYNC, DATA, STUFF: begin
          if (!bit_end) begin
            bit_timer <= bit_timer - 1'b1;
          end else begin
            bit_timer <= TC_LOAD;
            if (state == DATA && stuff_due) begin
              state    <= STUFF;
              ones_cnt <= 3'd0;
              d_plus   <= ~d_plus;
              d_minus  <= d_plus;
            end else if (byte_end && (shift_last || !have_next)) begin
              state    <= EOP_SE0;
              bit_idx  <= 3'd0;
              d_plus   <= 1'b0;
              d_minus  <= 1'b0;
              tx_error <= !shift_last;
            end else begin
              state   <= DATA;
              bit_idx <= adv_idx;
              if (byte_end) begin
                shift_data <= next_data;
                shift_last <= next_last;
              end
              if (adv_bit) begin
                ones_cnt <= (ones_cnt == 3'd7) ? 3'd7 : ones_cnt + 3'd1;
              end else begin
                ones_cnt <= 3'd0;
                d_plus   <= ~d_plus;
                d_minus  <= d_plus;
              end
            end
          end
        end

        EOP_SE0: begin
          if (!bit_end) begin
            bit_timer <= bit_timer - 1'b1;
          end else begin
            bit_timer <= TC_LOAD;
            if (bit_idx == 3'd0) begin
              bit_idx <= 3'd1;
            end else begin
              state   <= EOP_J;
              d_plus  <= 1'b1;
              d_minus <= 1'b0;
            end
          end
        end

        EOP_J: begin
          if (!bit_end) begin
            bit_timer <= bit_timer - 1'b1;
          end else begin
            state        <= IDLE;
            transmitting <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          d_plus       <= 1'b1;
          d_minus      <= 1'b0;
          transmitting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_transmitter.sv
// Self-checking bench for usb_transmitter: per-cycle line scoreboard from a bit-level NRZI model,
// plus table constants for line patterns, packet lengths and error pulses.
module tb_usb_transmitter;

  localparam int CPB = 8;
`ifdef USB_TX_BIT_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       transmitting;
  logic       tx_error;

  usb_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .transmitting (transmitting),
    .tx_error     (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected per-cycle {d_plus, d_minus, transmitting, tx_ready, tx_error}
  logic [4:0] sb[$];
  logic [7:0] pkt[4];
  bit         mline;
  int         mones;

  typedef struct {
    logic [7:0]  data;
    bit          last;
    int          len;
    logic [15:0] pat;
    bit          err;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic push_bit(input logic dp, input logic dm, input logic rf, input logic rr,
                          input logic ef);
    for (int c = 0; c < CPB; c++) begin
      if (c == 0) sb.push_back({dp, dm, 1'b1, rf, ef});
      else        sb.push_back({dp, dm, 1'b1, rr, 1'b0});
    end
  endtask

  task automatic push_nrzi(input bit v, input bit rf, input bit rr);
    if (!v) begin
      mline = !mline;
      mones = 0;
    end else begin
      mones++;
    end
    push_bit(mline, !mline, rf, rr, 1'b0);
    if (STUFF_EN && mones == 6) begin
      mline = !mline;
      mones = 0;
      push_bit(mline, !mline, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic model_packet(input int n, input bit abort);
    bit more;
    mline = 1'b1;
    mones = 0;
    for (int i = 0; i < 8; i++) push_nrzi(i == 7, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      more = (k < n - 1);
      for (int j = 0; j < 8; j++)
        push_nrzi(pkt[k][j], (j == 7) && (more || abort), (j == 7) && abort && !more);
    end
    push_bit(1'b0, 1'b0, 1'b0, 1'b0, abort);
    push_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(5'b10010);
  endtask

  // Called just after a rising edge; drives the packet and drains the scoreboard.
  task automatic run_packet(input int n, input bit lastf, input int exp_len,
                            input bit chk_pat, input logic [15:0] exp_pat, input bit exp_err);
    int          idx = 0;
    int          guard = 0;
    int          cyc = 0;
    int          tcount = 0;
    int          ecount = 0;
    bit          started = 1'b0;
    bit          acc;
    logic [15:0] pat = '0;
    logic [4:0]  e;
    logic [4:0]  a;
    tx_data  = pkt[0];
    tx_last  = (n == 1) ? lastf : 1'b0;
    tx_valid = 1'b1;
    while ((!started || sb.size() != 0) && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (started) begin
        e = sb.pop_front();
        a = {d_plus, d_minus, transmitting, tx_ready, tx_error};
        chk($sformatf("stream[%0d] {dp,dm,tr,rdy,err}", cyc), int'(a), int'(e));
        if (transmitting) tcount++;
        if (tx_error) ecount++;
        if (cyc % CPB == 0 && cyc / CPB < 16) pat = {pat[14:0], d_plus};
        cyc++;
      end
      acc = tx_valid && tx_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        started = 1'b1;
        idx++;
        if (idx < n) begin
          tx_data = pkt[idx];
          tx_last = (idx == n - 1) ? lastf : 1'b0;
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
        end
      end
    end
    chk("packet_completed", int'(started && sb.size() == 0), 1);
    sb.delete();
    tx_valid = 1'b0;
    chk("transmitting_cycles", tcount, exp_len);
    chk("tx_error_pulses", ecount, int'(exp_err));
    if (chk_pat) chk("line_pattern", int'(pat), int'(exp_pat));
  endtask

  initial begin
    int mlen;
    tbl[0] = '{8'h00, 1'b1, 152, 16'h54AA, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, STUFF_EN ? 160 : 152, STUFF_EN ? 16'h5407 : 16'h5400, 1'b0};
    tbl[2] = '{8'hA5, 1'b0, 152, 16'h546C, 1'b1};

    n_rst    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset d_plus", int'(d_plus), 1);
    chk("reset d_minus", int'(d_minus), 0);
    chk("reset tx_ready", int'(tx_ready), 1);
    chk("reset transmitting", int'(transmitting), 0);
    chk("reset tx_error", int'(tx_error), 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 3; t++) begin
      pkt[0] = tbl[t].data;
      model_packet(1, !tbl[t].last);
      run_packet(1, tbl[t].last, tbl[t].len, 1'b1, tbl[t].pat, tbl[t].err);
      repeat (3) @(posedge clk);
      #1;
    end

    // back-to-back payload bytes, with runs of ones that straddle byte edges
    pkt[0] = 8'h3C;
    pkt[1] = 8'hFF;
    pkt[2] = 8'h7E;
    model_packet(3, 1'b0);
    mlen = sb.size() - 1;
    run_packet(3, 1'b1, mlen, 1'b0, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of a data byte
    tx_data  = 8'h55;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid-packet transmitting", int'(transmitting), 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async reset d_plus", int'(d_plus), 1);
    chk("async reset d_minus", int'(d_minus), 0);
    chk("async reset transmitting", int'(transmitting), 0);
    chk("async reset tx_ready", int'(tx_ready), 1);
    @(negedge clk);
    chk("reset sample line", int'({d_plus, d_minus}), 2);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    pkt[0] = tbl[0].data;
    model_packet(1, 1'b0);
    run_packet(1, 1'b1, tbl[0].len, 1'b1, tbl[0].pat, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
